// File: rtl/door_code_sender.sv
// Purpose: plays a 1..3 digit code into a keypad lock as timed button presses, then waits for the lock verdict.
// Latency: start after the go edge; first press GAP_CYC cycles later; each digit PRESS_CYC+GAP_CYC; verdict wait up to RESP_TIMEOUT.
// Backpressure: go is taken only in IDLE; requests while busy are dropped; the lock has no flow control.
module door_code_sender #(
    parameter int PRESS_CYC    = 4,
    parameter int GAP_CYC      = 4,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       go,
    input  logic [1:0] code_len,
    input  logic [5:0] code,
    input  logic       led_ok,
    input  logic       led_fail,
    output logic       start,
    output logic       button_0,
    output logic       button_1,
    output logic       button_2,
    output logic       busy,
    output logic       done,
    output logic       res_ok,
    output logic       res_fail,
    output logic       res_timeout,
    output logic       res_err
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PRESS,
        GAP,
        WAIT_RES,
        DONE
    } state_t;

    // Terminal counts; counters run 0..LAST so 8 bits never wrap for 1..255.
    localparam logic [7:0] PRESS_LAST = 8'(PRESS_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
    localparam logic [7:0] TMO_LAST   = 8'(RESP_TIMEOUT - 1);

    state_t     state;
    logic [5:0] code_q;
    logic [1:0] len_q;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic [7:0] tmr;
    logic [2:0] btn;
    logic       req_ok;
    logic       more_digits;

    // Digit value 3 has no button, so it is rejected for every digit actually sent.
    assign req_ok = (code_len != 2'd0)
                 && (code[1:0] != 2'd3)
                 && !((code_len >= 2'd2) && (code[3:2] == 2'd3))
                 && !((code_len == 2'd3) && (code[5:4] == 2'd3));

    // True when the digit just finished is not the last one.
    assign more_digits = ({1'b0, idx} + 3'd1) < {1'b0, len_q};

    assign button_0 = btn[0];
    assign button_1 = btn[1];
    assign button_2 = btn[2];

    function automatic logic [1:0] digit_at(input logic [5:0] c, input logic [1:0] i);
        case (i)
            2'd0:    digit_at = c[1:0];
            2'd1:    digit_at = c[3:2];
            default: digit_at = c[5:4];
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] d);
        case (d)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // Session sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            code_q      <= 6'd0;
            len_q       <= 2'd0;
            idx         <= 2'd0;
            cnt         <= 8'd0;
            tmr         <= 8'd0;
            btn         <= 3'b000;
            start       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_ok      <= 1'b0;
            res_fail    <= 1'b0;
            res_timeout <= 1'b0;
            res_err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    btn   <= 3'b000;
                    if (go) begin
                        res_ok      <= 1'b0;
                        res_fail    <= 1'b0;
                        res_timeout <= 1'b0;
                        if (req_ok) begin
                            res_err <= 1'b0;
                            code_q  <= code;
                            len_q   <= code_len;
                            idx     <= 2'd0;
                            cnt     <= 8'd0;
                            start   <= 1'b1;
                            busy    <= 1'b1;
                            state   <= ARM;
                        end else begin
                            // Bad request: report and stay idle, lock never enabled.
                            res_err <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= 8'd0;
                        btn   <= onehot(digit_at(code_q, idx));
                        state <= PRESS;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PRESS: begin
                    if (cnt == PRESS_LAST) begin
                        cnt   <= 8'd0;
                        btn   <= 3'b000;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= 8'd0;
                        if (more_digits) begin
                            idx   <= idx + 2'd1;
                            btn   <= onehot(digit_at(code_q, idx + 2'd1));
                            state <= PRESS;
                        end else begin
                            tmr   <= 8'd0;
                            state <= WAIT_RES;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_RES: begin
                    // A fail verdict outranks ok; timeout only if neither arrives.
                    if (led_fail || led_ok || (tmr == TMO_LAST)) begin
                        res_fail    <= led_fail;
                        res_ok      <= !led_fail && led_ok;
                        res_timeout <= !led_fail && !led_ok;
                        start       <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_code_sender.sv
// Directed bench for door_code_sender: stimulus queues expected session results, a monitor checks them.
// Timing: inputs change 1ns after rising edges, outputs are sampled on falling edges.
// Default parameters: PRESS_CYC=4, GAP_CYC=4, RESP_TIMEOUT=64.
module tb_door_code_sender;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       go;
    logic [1:0] code_len;
    logic [5:0] code;
    logic       led_ok;
    logic       led_fail;
    logic       start;
    logic       button_0;
    logic       button_1;
    logic       button_2;
    logic       busy;
    logic       done;
    logic       res_ok;
    logic       res_fail;
    logic       res_timeout;
    logic       res_err;

    door_code_sender dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .go         (go),
        .code_len   (code_len),
        .code       (code),
        .led_ok     (led_ok),
        .led_fail   (led_fail),
        .start      (start),
        .button_0   (button_0),
        .button_1   (button_1),
        .button_2   (button_2),
        .busy       (busy),
        .done       (done),
        .res_ok     (res_ok),
        .res_fail   (res_fail),
        .res_timeout(res_timeout),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;

    // flags order: {ok, fail, timeout, err}; tail = low cycles with start high after the last press, -1 = skip
    typedef struct {
        logic [3:0] flags;
        int         n;
        int         d0;
        int         d1;
        int         d2;
        int         tail;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_pushed = 0;
    int   n_done   = 0;

    function automatic void check(string name, int got, int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endfunction

    function automatic void expect_session(logic [3:0] f, int n, int d0, int d1, int d2, int tail);
        exp_t e;
        e.flags = f; e.n = n; e.d0 = d0; e.d1 = d1; e.d2 = d2; e.tail = tail;
        exp_q.push_back(e);
        n_pushed++;
    endfunction

    // ---------------- monitor ----------------
    int         seq[3];
    int         nseq      = 0;
    int         low_run   = 0;
    int         plen      = 0;
    int         cur_prev  = -1;
    logic       start_prev = 1'b0;
    logic       post_done = 1'b0;
    logic [3:0] last_flags = 4'd0;

    always @(negedge clk) begin
        int   cur;
        exp_t e;
        if (n_rst !== 1'b1) begin
            nseq = 0; low_run = 0; plen = 0; cur_prev = -1; start_prev = 1'b0; post_done = 1'b0;
        end else begin
            if (post_done) begin
                check("busy_after_done", busy, 0);
                check("flags_sticky", {res_ok, res_fail, res_timeout, res_err}, last_flags);
                post_done = 1'b0;
            end
            if ((button_0 + button_1 + button_2) > 1)
                check("buttons_onehot", button_0 + button_1 + button_2, 1);
            cur = button_0 ? 0 : button_1 ? 1 : button_2 ? 2 : -1;
            if (start && !start_prev) nseq = 0;
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_flags", {res_ok, res_fail, res_timeout, res_err}, e.flags);
                    check("start_in_done", start, 0);
                    check("press_count", nseq, e.n);
                    if (e.n >= 1) check("digit0", seq[0], e.d0);
                    if (e.n >= 2) check("digit1", seq[1], e.d1);
                    if (e.n >= 3) check("digit2", seq[2], e.d2);
                    if (e.tail >= 0) check("wait_tail", low_run, e.tail);
                end
                last_flags = {res_ok, res_fail, res_timeout, res_err};
                post_done = 1'b1;
                nseq = 0;
            end
            if (cur != -1 && cur_prev == -1) begin
                check(nseq == 0 ? "arm_len" : "gap_len", low_run, 4);
                if (nseq < 3) seq[nseq] = cur;
                nseq++;
                plen = 1;
            end else if (cur != -1) begin
                plen++;
            end else if (cur_prev != -1) begin
                check("press_len", plen, 4);
            end
            if (cur == -1 && start) low_run++;
            else low_run = 0;
            cur_prev = cur;
            start_prev = start;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Caller sits 1ns after an edge; go is sampled at the next edge (edge N).
    task automatic issue_go(input logic [1:0] len, input logic [5:0] c);
        code_len = len;
        code     = c;
        go       = 1'b1;
        wait_edges(1);
        go       = 1'b0;
    endtask

    task automatic run_to_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            wait_edges(1);
            if (busy === 1'b0) break;
        end
        if (i == 300) check("idle_timeout", 1, 0);
        wait_edges(3);
    endtask

    initial begin
        n_rst = 1'b0; go = 1'b0; code_len = 2'd0; code = 6'd0; led_ok = 1'b0; led_fail = 1'b0;
        wait_edges(3);
        check("reset_outputs",
              {start, button_0, button_1, button_2, busy, done, res_ok, res_fail, res_timeout, res_err}, 0);
        n_rst = 1'b1;
        wait_edges(2);

        // digits 2,0; stray led_fail during ARM ignored; led_ok 3 cycles into WAIT_RES (entry N+20)
        expect_session(4'b1000, 2, 2, 0, 0, 7);
        issue_go(2'd2, 6'b00_00_10);
        led_fail = 1'b1;
        wait_edges(2);
        led_fail = 1'b0;
        wait_edges(20);
        led_ok = 1'b1;
        wait_edges(1);
        led_ok = 1'b0;
        run_to_idle();

        // digits 1,1,2; both verdicts 2 cycles into WAIT_RES (entry N+28) -> fail wins
        expect_session(4'b0100, 3, 1, 1, 2, 6);
        issue_go(2'd3, 6'b10_01_01);
        wait_edges(29);
        led_ok = 1'b1; led_fail = 1'b1;
        wait_edges(1);
        led_ok = 1'b0; led_fail = 1'b0;
        run_to_idle();

        // digit 0, no verdict -> timeout 64 cycles after WAIT_RES entry (tail = 4 gap + 64)
        expect_session(4'b0010, 1, 0, 0, 0, 68);
        issue_go(2'd1, 6'b00_00_00);
        run_to_idle();

        // invalid requests: zero length, and digit 1 = 3
        expect_session(4'b0001, 0, 0, 0, 0, -1);
        issue_go(2'd0, 6'b00_00_00);
        run_to_idle();
        expect_session(4'b0001, 0, 0, 0, 0, -1);
        issue_go(2'd2, 6'b00_11_00);
        run_to_idle();

        // digit 2 = 3 is beyond code_len and must not matter; verdict 1 cycle in
        expect_session(4'b1000, 2, 2, 1, 0, 5);
        issue_go(2'd2, 6'b11_01_10);
        wait_edges(20);
        led_ok = 1'b1;
        wait_edges(1);
        led_ok = 1'b0;
        run_to_idle();

        // go re-pulsed with other code during first press is ignored
        expect_session(4'b1000, 2, 0, 1, 0, 5);
        issue_go(2'd2, 6'b00_01_00);
        wait_edges(5);
        code_len = 2'd3; code = 6'b10_10_10; go = 1'b1;
        wait_edges(1);
        go = 1'b0;
        wait_edges(14);
        led_ok = 1'b1;
        wait_edges(1);
        led_ok = 1'b0;
        run_to_idle();

        // reset during the second press, then go on the first edge after release
        issue_go(2'd2, 6'b00_10_01);
        wait_edges(13);
        n_rst = 1'b0;
        wait_edges(1);
        check("midpress_reset_outputs",
              {start, button_0, button_1, button_2, busy, done, res_ok, res_fail, res_timeout, res_err}, 0);
        expect_session(4'b1000, 1, 2, 0, 0, 5);
        n_rst = 1'b1;
        issue_go(2'd1, 6'b00_00_10);
        check("go_after_reset_accepted", {start, busy}, 2'b11);
        wait_edges(12);
        led_ok = 1'b1;
        wait_edges(1);
        led_ok = 1'b0;
        run_to_idle();

        wait_edges(5);
        check("queue_drained", exp_q.size(), 0);
        check("done_count", n_done, n_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/door_code_sender.md
DOOR_CODE_SENDER -- requirements
Module: door_code_sender

Interface
REQ-001 The block SHALL have parameter PRESS_CYC, default 4, giving cycles each button is held high (legal 1..255).
REQ-002 The block SHALL have parameter GAP_CYC, default 4, giving cycles of all-buttons-low before each press and after the last press (legal 1..255).
REQ-003 The block SHALL have parameter RESP_TIMEOUT, default 64, giving cycles to wait for a lock verdict (legal 1..255).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 n_rst  input  1  reset, synchronous, active-low.
REQ-006 go  input  1  request to send code; sampled only in IDLE.
REQ-007 code_len  input  2  number of digits to send (1..3).
REQ-008 code  input  6  digits, 2 bits each, digit 0 in code[1:0], digit 1 in code[3:2], digit 2 in code[5:4]; digit value selects button 0/1/2.
REQ-009 led_ok, led_fail  input  1 each  verdict from lock.
REQ-010 start  output  1  session enable to lock.
REQ-011 button_0, button_1, button_2  output  1 each  button drive to lock.
REQ-012 busy  output  1  high from go acceptance until return to IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 res_ok, res_fail, res_timeout, res_err  output  1 each  sticky result flags.

Function
REQ-015 All outputs SHALL be registered; at most one button output SHALL be high in any cycle.
REQ-016 FSM states SHALL be IDLE, ARM, PRESS, GAP, WAIT_RES, DONE.
REQ-017 IDLE: start, buttons, busy = 0; on go=1 with valid request, latch code and code_len, clear all res_* flags, go to ARM.
REQ-018 A request SHALL be invalid if code_len=0 or any digit with index < code_len equals 3; then next cycle res_err=1, done=1 for one cycle, start stays 0, state stays IDLE.
REQ-019 ARM: start=1, busy=1, all buttons low for GAP_CYC cycles, then PRESS with digit index 0.
REQ-020 PRESS: drive button selected by current digit high for exactly PRESS_CYC cycles, then GAP.
REQ-021 GAP: all buttons low for GAP_CYC cycles; if index < code_len-1 then increment index and go to PRESS, else go to WAIT_RES with timer cleared.
REQ-022 WAIT_RES: start held 1; led_fail=1 -> DONE with res_fail; else led_ok=1 -> DONE with res_ok; led_fail has priority when both high.
REQ-023 WAIT_RES: if no verdict within RESP_TIMEOUT cycles, go to DONE with res_timeout=1.
REQ-024 led_ok/led_fail SHALL be ignored in every state except WAIT_RES.
REQ-025 DONE: start=0, done=1 for exactly one cycle, busy=0 from the following cycle, state to IDLE.
REQ-026 res_* flags SHALL hold until the next accepted go or reset; exactly one SHALL be set after each done.
REQ-027 go while busy=1 SHALL be ignored, with no effect on latched code or sequence.
REQ-028 Timing from go sampled at edge N: start=1 after edge N; first button high after edge N+GAP_CYC for PRESS_CYC cycles.
REQ-029 Cycle counter and timeout counter SHALL be 8-bit and SHALL not wrap within legal parameter ranges.

Reset
REQ-030 n_rst=0 at a rising edge SHALL force IDLE, digit index 0, counters 0, and all outputs 0, including mid-press or mid-wait.
REQ-031 The first go SHALL be accepted on the first edge after n_rst returns high.

Verification
REQ-032 code_len=2, code=6'b00_00_10 (digits 2,0), led_ok pulsed 3 cycles into WAIT_RES -> button_2 high 4 cycles, 4 low, button_0 high 4 cycles, done pulse, res_ok=1, start falls in DONE.
REQ-033 code_len=3, digits 1,1,2, led_fail and led_ok both high in same WAIT_RES cycle -> res_fail=1, res_ok=0.
REQ-034 code_len=1, digit 0, no verdict -> res_timeout=1 with done exactly 64 cycles after WAIT_RES entry; start=1 throughout wait.
REQ-035 code_len=0, then code_len=2 with digit 1=3 -> each gives res_err=1 and one done pulse; start and buttons stay 0.
REQ-036 go re-pulsed during PRESS -> ignored, sequence unchanged; n_rst=0 during second press -> all outputs 0 after that edge, new go accepted after release.
